// File: rtl/peripheral_ahb3_pkg.sv
// AHB3-Lite encodings and the APB4-slave to AHB3-master bridge state type.
// Shared by the bridge top and its strobe decoder.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [3:0] HPROT_OPCODE     = 4'b0000;
    localparam logic [3:0] HPROT_DATA       = 4'b0001;
    localparam logic [3:0] HPROT_PRIVILEGED = 4'b0010;
    localparam logic [3:0] HPROT_BUFFERABLE = 4'b0100;
    localparam logic [3:0] HPROT_CACHEABLE  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ACK  = 2'b11
    } bridge_state_t;

endpackage

// File: rtl/peripheral_apb4_pstrb_decode.sv
// Maps an APB4 write strobe onto an AHB transfer size and byte offset.
// Combinational; reads always decode as an aligned word.
module peripheral_apb4_pstrb_decode
    import peripheral_ahb3_pkg::*;
(
    input  logic [3:0] pstrb,
    input  logic       pwrite,
    output logic [2:0] hsize,
    output logic [1:0] offset,
    output logic       illegal
);

    always_comb begin
        hsize   = HSIZE_WORD;
        offset  = 2'd0;
        illegal = 1'b0;
        if (pwrite) begin
            case (pstrb)
                4'b1111: hsize = HSIZE_WORD;
                4'b0011: hsize = HSIZE_HWORD;
                4'b1100: begin hsize = HSIZE_HWORD; offset = 2'd2; end
                4'b0001: hsize = HSIZE_BYTE;
                4'b0010: begin hsize = HSIZE_BYTE; offset = 2'd1; end
                4'b0100: begin hsize = HSIZE_BYTE; offset = 2'd2; end
                4'b1000: begin hsize = HSIZE_BYTE; offset = 2'd3; end
                // includes the empty strobe; the top tells the two apart
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/peripheral_apb4slv2ahb3mst.sv
// Reissues each APB4 access as one single AHB3-Lite transfer in the same clock domain.
// Two APB wait states minimum; PREADY is held low until the AHB data phase completes.
module peripheral_apb4slv2ahb3mst
    import peripheral_ahb3_pkg::*;
#(
    parameter int                    HADDR_SIZE = 32,
    parameter int                    HDATA_SIZE = 32,
    parameter int                    PADDR_SIZE = 16,
    parameter int                    PDATA_SIZE = 32,
    parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
    input  logic                    HCLK,
    input  logic                    HRESET,

    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,

    output logic [HADDR_SIZE-1:0]   HADDR,
    output logic [HDATA_SIZE-1:0]   HWDATA,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [1:0]              HTRANS,
    output logic                    HMASTLOCK,
    input  logic [HDATA_SIZE-1:0]   HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    bridge_state_t state, state_d;

    logic [PDATA_SIZE-1:0] wdata_q, wdata_d;
    logic [PDATA_SIZE-1:0] prdata_d;
    logic                  pready_d, pslverr_d;
    logic [HADDR_SIZE-1:0] haddr_d;
    logic [HDATA_SIZE-1:0] hwdata_d;
    logic                  hwrite_d;
    logic [2:0]            hsize_d;
    logic [3:0]            hprot_d;
    logic [1:0]            htrans_d;

    logic [2:0] dec_hsize;
    logic [1:0] dec_offset;
    logic       dec_illegal;

    // PPROT[1] has no AHB3 counterpart and the low PADDR bits come from the strobe decode
    logic unused_apb;
    assign unused_apb = ^{PPROT[1], PADDR[1:0]};

    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;

    peripheral_apb4_pstrb_decode u_pstrb_decode (
        .pstrb   (PSTRB),
        .pwrite  (PWRITE),
        .hsize   (dec_hsize),
        .offset  (dec_offset),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d   = state;
        wdata_d   = wdata_q;
        prdata_d  = PRDATA;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        haddr_d   = HADDR;
        hwdata_d  = HWDATA;
        hwrite_d  = HWRITE;
        hsize_d   = HSIZE;
        hprot_d   = HPROT;
        htrans_d  = HTRANS;

        case (state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    wdata_d  = PWDATA;
                    hwrite_d = PWRITE;
                    hsize_d  = dec_hsize;
                    haddr_d  = HADDR_BASE | HADDR_SIZE'({PADDR[PADDR_SIZE-1:2], dec_offset});
                    hprot_d  = {2'b00, PPROT[0], ~PPROT[2]};
                    if (dec_illegal) begin
                        // an empty strobe is a harmless no-op, any other bad pattern is an error
                        state_d   = ST_ACK;
                        pready_d  = 1'b1;
                        pslverr_d = |PSTRB;
                    end else begin
                        state_d  = ST_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                    end
                end
            end

            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                end
            end

            ST_DATA: begin
                if (HREADY) begin
                    state_d  = ST_ACK;
                    pready_d = 1'b1;
                    if (HRESP == HRESP_ERROR) begin
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end else if (!HWRITE) begin
                        prdata_d = HRDATA;
                    end
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            wdata_q <= '0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            HADDR   <= '0;
            HWDATA  <= '0;
            HWRITE  <= 1'b0;
            HSIZE   <= HSIZE_WORD;
            HPROT   <= HPROT_DATA | HPROT_PRIVILEGED;
            HTRANS  <= HTRANS_IDLE;
        end else begin
            state   <= state_d;
            wdata_q <= wdata_d;
            PRDATA  <= prdata_d;
            PREADY  <= pready_d;
            PSLVERR <= pslverr_d;
            HADDR   <= haddr_d;
            HWDATA  <= hwdata_d;
            HWRITE  <= hwrite_d;
            HSIZE   <= hsize_d;
            HPROT   <= hprot_d;
            HTRANS  <= htrans_d;
        end
    end

endmodule

// File: tb/tb_peripheral_apb4slv2ahb3mst.sv
// Directed bench: APB master stimulus, behavioural AHB slave, scoreboard queues.
module tb_peripheral_apb4slv2ahb3mst;
    import peripheral_ahb3_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [3:0]  prot;
    } ahb_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic [7:0]  lat;
    } rsp_exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] HADDR, HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY, HRESP;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_prdata;
    ahb_exp_t ahb_q[$];
    rsp_exp_t rsp_q[$];

    always #5 HCLK = ~HCLK;

    peripheral_apb4slv2ahb3mst #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .PADDR_SIZE (16),
        .PDATA_SIZE (32),
        .HADDR_BASE (32'h4000_0000)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ahb();
        ahb_exp_t ea;
        check("ahb_pending", 32'(ahb_q.size() != 0), 32'd1);
        if (ahb_q.size() != 0) begin
            ea = ahb_q.pop_front();
            check("haddr",     HADDR,             ea.addr);
            check("hsize",     32'(HSIZE),        32'(ea.size));
            check("hwrite",    32'(HWRITE),       32'(ea.wr));
            check("hprot",     32'(HPROT),        32'(ea.prot));
            check("hburst",    32'(HBURST),       32'(HBURST_SINGLE));
            check("hmastlock", 32'(HMASTLOCK),    32'd0);
        end
    endtask

    // One APB access; the bench plays the AHB slave with aw address waits and dw data waits.
    task automatic apb_xfer(input logic wr, input logic [15:0] pa, input logic [3:0] st,
                            input logic [31:0] wd, input logic [2:0] pp, input int aw,
                            input int dw, input bit err, input logic [31:0] rd, input bit drop);
        logic [2:0] sz;
        logic [1:0] off;
        bit ill, noxfer, done, data_ph, acc;
        int c, awl, left, nonseq;
        ahb_exp_t ea;
        rsp_exp_t er, eo;

        ill = 1'b0; sz = HSIZE_WORD; off = 2'd0;
        if (wr) begin
            case (st)
                4'b1111: sz = HSIZE_WORD;
                4'b0011: sz = HSIZE_HWORD;
                4'b1100: begin sz = HSIZE_HWORD; off = 2'd2; end
                4'b0001: sz = HSIZE_BYTE;
                4'b0010: begin sz = HSIZE_BYTE; off = 2'd1; end
                4'b0100: begin sz = HSIZE_BYTE; off = 2'd2; end
                4'b1000: begin sz = HSIZE_BYTE; off = 2'd3; end
                default: ill = 1'b1;
            endcase
        end
        noxfer = wr && ill;
        if (!noxfer) begin
            ea.addr = 32'h4000_0000 | ({16'h0, pa} & 32'hFFFF_FFFC) | {30'b0, off};
            ea.size = sz;
            ea.wr   = wr;
            ea.prot = {2'b00, pp[0], ~pp[2]};
            ahb_q.push_back(ea);
            er.slverr = err;
            er.lat    = 8'(3 + aw + (err ? 1 : dw));
            if (err)      model_prdata = 32'h0;
            else if (!wr) model_prdata = rd;
        end else begin
            er.slverr = (st != 4'b0000);
            er.lat    = 8'd1;
        end
        er.rdata = model_prdata;
        rsp_q.push_back(er);

        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = pa; PSTRB = st;
        PWDATA = wd; PPROT = pp; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hBAD0_BAD0;
        c = 0; done = 1'b0; data_ph = 1'b0; awl = aw; left = err ? 1 : dw; nonseq = 0;

        while (!done && c < 40) begin
            @(negedge HCLK);
            acc = (HTRANS == HTRANS_NONSEQ) && HREADY;
            if (acc) begin
                nonseq++;
                check_ahb();
            end
            if (data_ph) begin
                check("data_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
                if (HREADY && wr) check("hwdata", HWDATA, wd);
            end
            if (PREADY) begin
                eo = rsp_q.pop_front();
                check("prdata",  PRDATA,        eo.rdata);
                check("pslverr", 32'(PSLVERR),  32'(eo.slverr));
                check("latency", 32'(c),        32'(eo.lat));
                done = 1'b1;
            end else begin
                check("pslverr_low", 32'(PSLVERR), 32'd0);
            end
            if (!done) begin
                @(posedge HCLK); #1;
                c++;
                if (data_ph && HREADY) data_ph = 1'b0;
                if (acc) data_ph = 1'b1;
                PENABLE = 1'b1;
                if (drop) begin PSEL = 1'b0; PENABLE = 1'b0; end
                HRESP = 1'b0; HRDATA = 32'hBAD0_BAD0;
                if (data_ph) begin
                    if (left > 0) begin HREADY = 1'b0; HRESP = err; left--; end
                    else begin HREADY = 1'b1; HRESP = err; HRDATA = rd; end
                end else if (HTRANS == HTRANS_NONSEQ) begin
                    if (awl > 0) begin HREADY = 1'b0; awl--; end
                    else HREADY = 1'b1;
                end else begin
                    HREADY = 1'b1;
                end
            end
        end
        check("completed",  32'(done),   32'd1);
        check("nonseq_cnt", 32'(nonseq), noxfer ? 32'd0 : 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0; HRESP = 1'b0; HREADY = 1'b1;
    endtask

    initial begin
        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
        PWDATA = '0; PSTRB = '0; PPROT = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        model_prdata = 32'h0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_pready",  32'(PREADY),    32'd0);
        check("rst_pslverr", 32'(PSLVERR),   32'd0);
        check("rst_prdata",  PRDATA,         32'd0);
        check("rst_htrans",  32'(HTRANS),    32'(HTRANS_IDLE));
        check("rst_haddr",   HADDR,          32'd0);
        check("rst_hwdata",  HWDATA,         32'd0);
        check("rst_hwrite",  32'(HWRITE),    32'd0);
        check("rst_hsize",   32'(HSIZE),     32'(HSIZE_WORD));
        check("rst_hburst",  32'(HBURST),    32'(HBURST_SINGLE));
        check("rst_hprot",   32'(HPROT),     32'b0011);
        check("rst_hmlock",  32'(HMASTLOCK), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        //        wr    paddr     strb     wdata          pprot  aw dw err hrdata        drop
        apb_xfer(1'b1, 16'h0010, 4'b1111, 32'hDEADBEEF, 3'b000, 0, 0, 0, 32'h0,        0);
        apb_xfer(1'b1, 16'h0020, 4'b0100, 32'h00AB0000, 3'b000, 0, 0, 0, 32'h0,        0);
        apb_xfer(1'b1, 16'h0020, 4'b1100, 32'hCAFE0000, 3'b001, 0, 0, 0, 32'h0,        0);
        apb_xfer(1'b0, 16'h0040, 4'b0000, 32'h0,        3'b100, 0, 2, 0, 32'h1234_5678, 0);
        apb_xfer(1'b1, 16'h0106, 4'b0011, 32'h0000BEEF, 3'b101, 1, 0, 0, 32'h0,        0);
        apb_xfer(1'b1, 16'h0033, 4'b1000, 32'h77000000, 3'b000, 0, 1, 0, 32'h0,        0);
        apb_xfer(1'b0, 16'h0080, 4'b1111, 32'h0,        3'b000, 0, 0, 1, 32'hFFFF_FFFF, 0);
        apb_xfer(1'b1, 16'h0090, 4'b0101, 32'h11111111, 3'b000, 0, 0, 0, 32'h0,        0);
        apb_xfer(1'b1, 16'h0094, 4'b0000, 32'h22222222, 3'b000, 0, 0, 0, 32'h0,        0);
        apb_xfer(1'b0, 16'h00A0, 4'b0000, 32'h0,        3'b000, 1, 0, 0, 32'hA5A5_0F0F, 0);
        apb_xfer(1'b1, 16'h00A4, 4'b1111, 32'h0BADF00D, 3'b000, 0, 0, 0, 32'h0,        0);
        apb_xfer(1'b1, 16'h00A8, 4'b0010, 32'h0000EE00, 3'b000, 1, 1, 1, 32'h0,        0);
        apb_xfer(1'b0, 16'h00B0, 4'b0000, 32'h0,        3'b000, 0, 1, 0, 32'h5A5A_1234, 1);

        // reset while the address phase is stalled
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h00C0; PSTRB = 4'b0000;
        @(posedge HCLK); #1;
        PENABLE = 1'b1; HREADY = 1'b0;
        @(negedge HCLK);
        check("mid_nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
        @(negedge HCLK);
        check("mid_rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        check("mid_rst_pready", 32'(PREADY), 32'd0);
        check("mid_rst_haddr",  HADDR,       32'd0);
        check("mid_rst_prdata", PRDATA,      32'd0);
        model_prdata = 32'h0;

        apb_xfer(1'b0, 16'h00C4, 4'b0000, 32'h0,        3'b000, 0, 0, 0, 32'h600D_D00D, 0);
        apb_xfer(1'b1, 16'h00C8, 4'b0001, 32'h000000AA, 3'b000, 0, 0, 0, 32'h0,        0);

        check("ahb_q_drained", 32'(ahb_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        repeat (2) @(posedge HCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
